// File: rtl/ram_stream_reader_if.sv
// Bundles the burst request, storage read port and output stream of ram_stream_reader.
// master: reader side; slave: requester/storage/consumer side.
interface ram_stream_reader_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, count, rd_data, out_ready,
    output rd_en, rd_addr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, count, rd_data, out_ready,
    input  rd_en, rd_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams count words from a 1-cycle-latency RAM starting at base_addr; one word per 3 cycles
// (ISSUE, WAIT, SEND), out_valid first high 3 cycles after start; SEND holds the word while out_ready=0.
module ram_stream_reader #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  ram_stream_reader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   REM_ZERO = '0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode from state only, so clear forces them low without waiting for an edge.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    data_d        = data_q;
    bus.rd_en     = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          if (bus.count != REM_ZERO) begin
            addr_d  = bus.base_addr;
            rem_d   = bus.count;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        bus.rd_en = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        data_d  = bus.rd_data;
        state_d = S_SEND;
      end
      S_SEND: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (rem_q == REM_ONE) begin
            state_d = S_DONE;
          end else begin
            rem_d   = rem_q - REM_ONE;
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.rd_addr  = addr_q;
  assign bus.out_data = data_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 1-cycle-latency 4x4 RAM model.
module tb_ram_stream_reader;

  logic clk = 1'b0;
  logic clear;

  ram_stream_reader_if #(.ADDR_W(2), .DATA_W(4)) bus ();

  ram_stream_reader #(.ADDR_W(2), .DATA_W(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [4];
  initial begin
    mem[0] = 4'b1010;
    mem[1] = 4'b1100;
    mem[2] = 4'b0011;
    mem[3] = 4'b1111;
  end

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  logic [3:0] xq [$];
  logic [1:0] aq [$];
  int         done_cnt = 0;

  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready) xq.push_back(bus.out_data);
    if (bus.rd_en) aq.push_back(bus.rd_addr);
    if (bus.done) done_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_burst(input logic [1:0] base, input logic [2:0] cnt);
    bus.base_addr = base;
    bus.count     = cnt;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt);
    int k;
    k = 0;
    while (done_cnt == start_cnt && k < 60) begin
      tick();
      k++;
    end
    check("done_timeout", 32'(done_cnt != start_cnt), 32'd1);
  endtask

  task automatic check_xfers(input string tag, input int n, input logic [15:0] exp_words);
    logic [3:0] w;
    check({tag, "_nxfer"}, 32'(xq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      w = exp_words[4*(n-1-i) +: 4];
      check({tag, "_xfer"}, (i < xq.size()) ? 32'(xq[i]) : 32'hDEAD, 32'(w));
    end
  endtask

  task automatic reset_logs();
    xq.delete();
    aq.delete();
  endtask

  int d0;

  initial begin
    clear         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_busy",  32'(bus.busy),      0);
    check("rst_rden",  32'(bus.rd_en),     0);
    check("rst_addr",  32'(bus.rd_addr),   0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data",  32'(bus.out_data),  0);
    check("rst_done",  32'(bus.done),      0);
    @(negedge clk);
    clear = 1'b0;
    tick();

    // Basic burst with exact cycle timing.
    reset_logs();
    d0 = done_cnt;
    start_burst(2'd1, 3'd2);
    check("b_rden_k1", 32'(bus.rd_en),   1);
    check("b_addr_k1", 32'(bus.rd_addr), 1);
    check("b_busy_k1", 32'(bus.busy),    1);
    tick();
    check("b_rden_k2", 32'(bus.rd_en),     0);
    check("b_val_k2",  32'(bus.out_valid), 0);
    tick();
    check("b_val_k3",  32'(bus.out_valid), 1);
    check("b_data_k3", 32'(bus.out_data),  4'b1100);
    tick();
    check("b_addr_k4", 32'(bus.rd_addr), 2);
    check("b_rden_k4", 32'(bus.rd_en),   1);
    tick();
    tick();
    check("b_data_k6", 32'(bus.out_data), 4'b0011);
    tick();
    check("b_done_k7", 32'(bus.done), 1);
    check("b_busy_k7", 32'(bus.busy), 1);
    tick();
    check("b_done_k8", 32'(bus.done), 0);
    check("b_busy_k8", 32'(bus.busy), 0);
    check_xfers("basic", 2, {8'h0, 4'b1100, 4'b0011});
    check("b_ndone", 32'(done_cnt - d0), 1);

    // Address wraps 3 -> 0.
    reset_logs();
    d0 = done_cnt;
    start_burst(2'd3, 3'd2);
    wait_done(d0);
    check("w_naddr", 32'(aq.size()), 2);
    check("w_addr0", (aq.size() > 0) ? 32'(aq[0]) : 32'hDEAD, 3);
    check("w_addr1", (aq.size() > 1) ? 32'(aq[1]) : 32'hDEAD, 0);
    check_xfers("wrap", 2, {8'h0, 4'b1111, 4'b1010});
    tick();

    // Zero-length burst.
    reset_logs();
    d0 = done_cnt;
    start_burst(2'd2, 3'd0);
    check("z_busy", 32'(bus.busy),  1);
    check("z_done", 32'(bus.done),  1);
    check("z_rden", 32'(bus.rd_en), 0);
    tick();
    check("z_idle", 32'(bus.busy), 0);
    check("z_done2", 32'(bus.done), 0);
    check("z_nrd", 32'(aq.size()), 0);
    check("z_ndone", 32'(done_cnt - d0), 1);

    // Backpressure: word held while out_ready is low.
    reset_logs();
    d0 = done_cnt;
    bus.out_ready = 1'b0;
    start_burst(2'd0, 3'd1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_data",  32'(bus.out_data),  4'b1010);
      check("bp_rden",  32'(bus.rd_en),     0);
      tick();
    end
    check("bp_nx_held", 32'(xq.size()), 0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_done", 32'(bus.done), 1);
    check_xfers("bp", 1, {12'h0, 4'b1010});
    tick();

    // Full depth with start re-pulsed mid-burst.
    reset_logs();
    d0 = done_cnt;
    start_burst(2'd2, 3'd4);
    tick();
    tick();
    tick();
    bus.base_addr = 2'd0;
    bus.count     = 3'd1;
    bus.start     = 1'b1;
    tick();
    tick();
    bus.start     = 1'b0;
    wait_done(d0);
    tick();
    check_xfers("full", 4, {4'b0011, 4'b1111, 4'b1010, 4'b1100});
    check("f_ndone", 32'(done_cnt - d0), 1);
    check("f_idle",  32'(bus.busy), 0);
    check("f_retain", 32'(bus.out_data), 4'b1100);

    // Asynchronous clear during SEND aborts the burst.
    reset_logs();
    d0 = done_cnt;
    bus.out_ready = 1'b0;
    start_burst(2'd1, 3'd2);
    tick();
    tick();
    check("r_insend", 32'(bus.out_valid), 1);
    #1 clear = 1'b1;
    #1;
    check("r_busy",  32'(bus.busy),      0);
    check("r_valid", 32'(bus.out_valid), 0);
    check("r_data",  32'(bus.out_data),  0);
    check("r_rden",  32'(bus.rd_en),     0);
    check("r_done",  32'(bus.done),      0);
    #1 clear = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) tick();
    check("r_nodone", 32'(done_cnt - d0), 0);
    check("r_idle", 32'(bus.busy), 0);
    start_burst(2'd3, 3'd1);
    check("r_restart", 32'(bus.rd_en), 1);
    check("r_raddr", 32'(bus.rd_addr), 3);
    wait_done(done_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
